// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: 2-flop synchroniser, 3-sample majority vote,
// false-start rejection, framing/overrun detection. Optional parity check via UART_RX_PARITY_EN.
module uart_rx_param #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned STOP_BITS  = 1,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid,
   input  logic                 ready,
   output logic                 framing_err,
   output logic                 parity_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned IDX_W = 4;
   localparam int unsigned MID   = OVERSAMPLE / 2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
   localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
   localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(MID + 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t               state, state_nxt;
   logic                 rx_meta, rx_s;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [IDX_W-1:0]     idx, idx_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic [1:0]           samp, samp_nxt;
   logic                 ferr, ferr_nxt;
   logic                 par_bit, par_bit_nxt;
   logic                 bit_val_c;
   logic                 dec_c;
   logic                 wrap_c;
   logic                 done_c;
   logic                 perr_c;

   // Line synchroniser, idles high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   assign bit_val_c = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
   assign dec_c     = (cnt == CNT_DEC);
   assign wrap_c    = (cnt == CNT_LAST);
   assign perr_c    = PAR_EN & (par_bit ^ (^shreg) ^ PARITY_ODD);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         samp    <= 2'b11;
         ferr    <= 1'b0;
         par_bit <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         idx     <= idx_nxt;
         shreg   <= shreg_nxt;
         samp    <= samp_nxt;
         ferr    <= ferr_nxt;
         par_bit <= par_bit_nxt;
      end
   end

   // Next-state and datapath update; everything advances on tick only
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      idx_nxt     = idx;
      shreg_nxt   = shreg;
      samp_nxt    = samp;
      ferr_nxt    = ferr;
      par_bit_nxt = par_bit;
      done_c      = 1'b0;
      if (tick) begin
         if (state != IDLE) cnt_nxt = wrap_c ? '0 : cnt + CNT_W'(1);
         if (cnt == CNT_S0) samp_nxt[0] = rx_s;
         if (cnt == CNT_S1) samp_nxt[1] = rx_s;
         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_nxt = START;
                  cnt_nxt   = '0;
                  idx_nxt   = '0;
                  ferr_nxt  = 1'b0;
               end
            end
            START: begin
               if (dec_c && bit_val_c) state_nxt = IDLE;
               else if (wrap_c)        state_nxt = DATA;
            end
            DATA: begin
               if (dec_c) shreg_nxt = {bit_val_c, shreg[DATA_BITS-1:1]};
               if (wrap_c) begin
                  if (idx == DATA_LAST) begin
                     idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
                     state_nxt = PARITY;
`else
                     state_nxt = STOP;
`endif
                  end else begin
                     idx_nxt = idx + IDX_W'(1);
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (dec_c)  par_bit_nxt = bit_val_c;
               if (wrap_c) state_nxt   = STOP;
            end
`endif
            STOP: begin
               if (dec_c) begin
                  if (!bit_val_c) ferr_nxt = 1'b1;
                  if (idx == STOP_LAST) begin
                     done_c    = 1'b1;
                     state_nxt = IDLE;
                  end
               end else if (wrap_c) begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Output holding register and consumer handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out    <= '0;
         valid       <= 1'b0;
         framing_err <= 1'b0;
         parity_err  <= 1'b0;
         overrun_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         if (done_c) begin
            if (!valid || ready) begin
               data_out    <= shreg;
               framing_err <= ferr_nxt;
               parity_err  <= perr_c;
               valid       <= 1'b1;
               if (valid) overrun_err <= 1'b0;
            end else begin
               overrun_err <= 1'b1;
            end
         end else if (valid && ready) begin
            valid       <= 1'b0;
            overrun_err <= 1'b0;
         end
      end
   end

endmodule
